// File: rtl/retire_stage.sv
// retire_stage: commits in-order ROB retire packets to the AMT and free list.
// Define RETIRE_STATS_EN to add the stat_retired/stat_squashes counters.
module retire_stage #(
    parameter int WAYS = 3,
    parameter int PHYS_BITS = 6,
    parameter int ARCH_BITS = 5,
    parameter int XLEN = 32,
    parameter int RECOVER_CYCLES = 2,
    localparam int CW = $clog2(WAYS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WAYS-1:0]           ret_valid,
    input  logic [WAYS*PHYS_BITS-1:0] ret_t_idx,
    input  logic [WAYS*PHYS_BITS-1:0] ret_told_idx,
    input  logic [WAYS*ARCH_BITS-1:0] ret_ar_idx,
    input  logic [WAYS-1:0]           ret_halt,
    input  logic [WAYS-1:0]           ret_pse,
    input  logic [WAYS*XLEN-1:0]      ret_target_pc,
    output logic [WAYS-1:0]           amt_we,
    output logic [WAYS*ARCH_BITS-1:0] amt_ar,
    output logic [WAYS*PHYS_BITS-1:0] amt_t,
    output logic [WAYS-1:0]           free_valid,
    output logic [WAYS*PHYS_BITS-1:0] free_idx,
    output logic                      squash,
    output logic [XLEN-1:0]           redirect_pc,
    output logic                      halted,
    output logic [CW-1:0]             retire_cnt,
    output logic                      protocol_err
`ifdef RETIRE_STATS_EN
   ,output logic [31:0]               stat_retired
   ,output logic [31:0]               stat_squashes
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [3:0]                rcnt_q, rcnt_d;
    logic [WAYS-1:0]           commit;
    logic                      gap, hit_pse, hit_halt;
    logic [XLEN-1:0]           tgt;
    logic [WAYS-1:0]           we_d, we_q, fv_d, fv_q;
    logic [WAYS*ARCH_BITS-1:0] ar_d, ar_q;
    logic [WAYS*PHYS_BITS-1:0] t_d, t_q, fi_d, fi_q;
    logic                      sq_d, sq_q, halt_d, halt_q;
    logic                      perr_d, perr_q;
    logic [XLEN-1:0]           pc_d, pc_q;
    logic [CW-1:0]             cnt_d, cnt_q;

    // Only the last committed way can carry pse/halt: commit stops after it.
    always_comb begin : qualify
        logic hole;
        logic stop;
        hole     = 1'b0;
        stop     = 1'b0;
        gap      = 1'b0;
        commit   = '0;
        hit_pse  = 1'b0;
        hit_halt = 1'b0;
        tgt      = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!ret_valid[i]) hole = 1'b1;
            else if (hole) gap = 1'b1;
            if (ret_valid[i] && !hole && !stop) begin
                commit[i] = 1'b1;
                if (ret_halt[i]) begin
                    hit_halt = 1'b1;
                end else if (ret_pse[i]) begin
                    hit_pse = 1'b1;
                    tgt     = ret_target_pc[i*XLEN +: XLEN];
                end
            end
            if (ret_valid[i] && (ret_pse[i] || ret_halt[i])) stop = 1'b1;
        end
    end

    always_comb begin : fsm
        state_d = state_q;
        rcnt_d  = rcnt_q;
        we_d    = '0;
        fv_d    = '0;
        ar_d    = '0;
        t_d     = '0;
        fi_d    = '0;
        sq_d    = 1'b0;
        pc_d    = pc_q;
        halt_d  = halt_q;
        perr_d  = perr_q;
        cnt_d   = '0;
        unique case (state_q)
            RUN: begin
                for (int i = 0; i < WAYS; i++) begin
                    if (commit[i]) begin
                        cnt_d = cnt_d + CW'(1);
                        if (ret_ar_idx[i*ARCH_BITS +: ARCH_BITS] != '0) begin
                            we_d[i] = 1'b1;
                            fv_d[i] = 1'b1;
                            ar_d[i*ARCH_BITS +: ARCH_BITS] =
                                ret_ar_idx[i*ARCH_BITS +: ARCH_BITS];
                            t_d[i*PHYS_BITS +: PHYS_BITS] =
                                ret_t_idx[i*PHYS_BITS +: PHYS_BITS];
                            fi_d[i*PHYS_BITS +: PHYS_BITS] =
                                ret_told_idx[i*PHYS_BITS +: PHYS_BITS];
                        end
                    end
                end
                if (gap) perr_d = 1'b1;
                if (hit_halt) begin
                    halt_d  = 1'b1;
                    state_d = HALTED;
                end else if (hit_pse) begin
                    sq_d    = 1'b1;
                    pc_d    = tgt;
                    state_d = RECOVER;
                    rcnt_d  = 4'(RECOVER_CYCLES);
                end
            end
            RECOVER: begin
                if (|ret_valid) perr_d = 1'b1;
                rcnt_d = rcnt_q - 4'd1;
                if (rcnt_q <= 4'd1) begin
                    rcnt_d  = '0;
                    state_d = RUN;
                end
            end
            HALTED: begin
                if (|ret_valid) perr_d = 1'b1;
            end
            default: begin
                state_d = RUN;
                rcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            rcnt_q  <= '0;
            we_q    <= '0;
            fv_q    <= '0;
            ar_q    <= '0;
            t_q     <= '0;
            fi_q    <= '0;
            sq_q    <= 1'b0;
            pc_q    <= '0;
            halt_q  <= 1'b0;
            perr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            we_q    <= we_d;
            fv_q    <= fv_d;
            ar_q    <= ar_d;
            t_q     <= t_d;
            fi_q    <= fi_d;
            sq_q    <= sq_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            perr_q  <= perr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign amt_we       = we_q;
    assign amt_ar       = ar_q;
    assign amt_t        = t_q;
    assign free_valid   = fv_q;
    assign free_idx     = fi_q;
    assign squash       = sq_q;
    assign redirect_pc  = pc_q;
    assign halted       = halt_q;
    assign retire_cnt   = cnt_q;
    assign protocol_err = perr_q;

`ifdef RETIRE_STATS_EN
    logic [31:0] sret_q, ssq_q;

    // Accumulate from next-state so the halting commit is still counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sret_q <= '0;
            ssq_q  <= '0;
        end else if (state_q != HALTED) begin
            sret_q <= sret_q + 32'(cnt_d);
            ssq_q  <= ssq_q + 32'(sq_d);
        end
    end

    assign stat_retired  = sret_q;
    assign stat_squashes = ssq_q;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: scoreboard bench for retire_stage (WAYS=3 defaults).
// Expected commit bundles are queued at drive time and popped one cycle later.
module tb_retire_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  ret_valid, ret_halt, ret_pse;
    logic [17:0] ret_t_idx, ret_told_idx;
    logic [14:0] ret_ar_idx;
    logic [95:0] ret_target_pc;
    logic [2:0]  amt_we, free_valid;
    logic [14:0] amt_ar;
    logic [17:0] amt_t, free_idx;
    logic        squash, halted, protocol_err;
    logic [31:0] redirect_pc;
    logic [1:0]  retire_cnt;
`ifdef RETIRE_STATS_EN
    logic [31:0] stat_retired, stat_squashes;
`endif

    retire_stage dut (
        .clock        (clock),
        .reset        (reset),
        .ret_valid    (ret_valid),
        .ret_t_idx    (ret_t_idx),
        .ret_told_idx (ret_told_idx),
        .ret_ar_idx   (ret_ar_idx),
        .ret_halt     (ret_halt),
        .ret_pse      (ret_pse),
        .ret_target_pc(ret_target_pc),
        .amt_we       (amt_we),
        .amt_ar       (amt_ar),
        .amt_t        (amt_t),
        .free_valid   (free_valid),
        .free_idx     (free_idx),
        .squash       (squash),
        .redirect_pc  (redirect_pc),
        .halted       (halted),
        .retire_cnt   (retire_cnt),
        .protocol_err (protocol_err)
`ifdef RETIRE_STATS_EN
       ,.stat_retired (stat_retired)
       ,.stat_squashes(stat_squashes)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  we;
        logic [14:0] ar;
        logic [17:0] t;
        logic [2:0]  fv;
        logic [17:0] fi;
        logic        sq;
        logic [31:0] pc;
        logic        h;
        logic [1:0]  cnt;
        logic        pe;
    } obs_t;

    obs_t       sb[$];
    obs_t       g, e;
    int         total  = 0;
    int         passed = 0;
    logic [5:0] amt[32];

    function automatic obs_t ex(
        input logic [2:0] we, input logic [14:0] ar,
        input logic [17:0] t, input logic [2:0] fv,
        input logic [17:0] fi, input logic sq,
        input logic [31:0] pc, input logic h,
        input logic [1:0] cnt, input logic pe);
        obs_t o;
        o.we = we; o.ar = ar; o.t = t; o.fv = fv; o.fi = fi;
        o.sq = sq; o.pc = pc; o.h = h; o.cnt = cnt; o.pe = pe;
        return o;
    endfunction

    // Index/data fields are don't-care on disabled ways.
    function automatic obs_t sample();
        obs_t o;
        o = ex(amt_we, amt_ar, amt_t, free_valid, free_idx, squash,
               redirect_pc, halted, retire_cnt, protocol_err);
        for (int i = 0; i < 3; i++) begin
            if (!amt_we[i]) begin
                o.ar[i*5 +: 5] = '0;
                o.t[i*6 +: 6]  = '0;
            end
            if (!free_valid[i]) o.fi[i*6 +: 6] = '0;
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(
        input logic [2:0] v, input logic [14:0] ar,
        input logic [17:0] t, input logic [17:0] told,
        input logic [2:0] h, input logic [2:0] p,
        input logic [95:0] pc);
        ret_valid = v; ret_ar_idx = ar; ret_t_idx = t;
        ret_told_idx = told; ret_halt = h; ret_pse = p;
        ret_target_pc = pc;
    endtask

    task automatic idle();
        drv(3'b000, '0, '0, '0, 3'b000, 3'b000, '0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        tick();
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drv(3'b111, {5'd1, 5'd2, 5'd3}, 18'h3ffff, 18'h1, 3'b000, 3'b111, '1);
        #1;
        g = sample(); total++;
        if (g !== ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL reset_async got=%h exp=0", g);
        else passed++;
        tick();
        g = sample(); total++;
        if (g !== ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL reset_held got=%h exp=0", g);
        else passed++;
        idle();
        #2 reset = 1'b1;
        tick();
        g = sample(); total++;
        if (g !== ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL reset_release got=%h exp=0", g);
        else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        drv(3'b111, {5'd7, 5'd5, 5'd3}, {6'd42, 6'd41, 6'd40},
            {6'd7, 6'd5, 6'd3}, 3'b000, 3'b000, '0);
        sb.push_back(ex(3'b111, {5'd7, 5'd5, 5'd3}, {6'd42, 6'd41, 6'd40},
                        3'b111, {6'd7, 6'd5, 6'd3}, 0, 0, 0, 2'd3, 0));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL basic got=%h exp=%h", g, e);
        else passed++;
        idle();
        sb.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL basic_idle got=%h exp=%h", g, e);
        else passed++;
    endtask

    task automatic test_ar_zero();
        do_reset();
        drv(3'b111, {5'd2, 5'd1, 5'd0}, {6'd21, 6'd20, 6'd0},
            {6'd12, 6'd11, 6'd9}, 3'b000, 3'b000, '0);
        sb.push_back(ex(3'b110, {5'd2, 5'd1, 5'd0}, {6'd21, 6'd20, 6'd0},
                        3'b110, {6'd12, 6'd11, 6'd0}, 0, 0, 0, 2'd3, 0));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL ar_zero got=%h exp=%h", g, e);
        else passed++;
    endtask

    task automatic test_squash();
        do_reset();
        drv(3'b111, {5'd9, 5'd8, 5'd6}, {6'd32, 6'd31, 6'd30},
            {6'd9, 6'd8, 6'd6}, 3'b000, 3'b010,
            {32'hdead, 32'h1000, 32'hbeef});
        sb.push_back(ex(3'b011, {5'd0, 5'd8, 5'd6}, {6'd0, 6'd31, 6'd30},
                        3'b011, {6'd0, 6'd8, 6'd6}, 1, 32'h1000, 0, 2'd2, 0));
        for (int k = 0; k < 2; k++) begin
            if (k == 0) tick();
            g = sample(); e = sb.pop_front(); total++;
            if (g !== e) $display("FAIL squash_c%0d got=%h exp=%h", k, g, e);
            else passed++;
            drv(3'b111, {5'd3, 5'd2, 5'd1}, {6'd3, 6'd2, 6'd1},
                {6'd6, 6'd5, 6'd4}, 3'b000, 3'b000, '0);
            sb.push_back(ex(0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 1));
            tick();
        end
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL squash_c2 got=%h exp=%h", g, e);
        else passed++;
        drv(3'b001, {5'd0, 5'd0, 5'd10}, {6'd0, 6'd0, 6'd33},
            {6'd0, 6'd0, 6'd10}, 3'b000, 3'b000, '0);
        sb.push_back(ex(3'b001, {5'd0, 5'd0, 5'd10}, {6'd0, 6'd0, 6'd33},
                        3'b001, {6'd0, 6'd0, 6'd10}, 0, 32'h1000, 0, 2'd1, 1));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL squash_resume got=%h exp=%h", g, e);
        else passed++;
    endtask

    task automatic test_halt();
        do_reset();
        drv(3'b111, {5'd9, 5'd8, 5'd3}, {6'd52, 6'd51, 6'd50},
            {6'd9, 6'd8, 6'd3}, 3'b001, 3'b000, '0);
        sb.push_back(ex(3'b001, {5'd0, 5'd0, 5'd3}, {6'd0, 6'd0, 6'd50},
                        3'b001, {6'd0, 6'd0, 6'd3}, 0, 0, 1, 2'd1, 0));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL halt got=%h exp=%h", g, e);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            drv(3'b111, {5'd3, 5'd2, 5'd1}, {6'd3, 6'd2, 6'd1},
                {6'd6, 6'd5, 6'd4}, 3'b000, 3'b010, '1);
            sb.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
            tick();
            g = sample(); e = sb.pop_front(); total++;
            if (g !== e) $display("FAIL halt_hold%0d got=%h exp=%h", k, g, e);
            else passed++;
        end
        reset = 1'b0;
        #1;
        g = sample(); total++;
        if (g !== ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL halt_reset got=%h exp=0", g);
        else passed++;
        #2 reset = 1'b1;
        drv(3'b001, {5'd0, 5'd0, 5'd2}, {6'd0, 6'd0, 6'd7},
            {6'd0, 6'd0, 6'd2}, 3'b000, 3'b000, '0);
        sb.push_back(ex(3'b001, {5'd0, 5'd0, 5'd2}, {6'd0, 6'd0, 6'd7},
                        3'b001, {6'd0, 6'd0, 6'd2}, 0, 0, 0, 2'd1, 0));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL halt_rerun got=%h exp=%h", g, e);
        else passed++;
    endtask

    task automatic test_same_ar();
        do_reset();
        amt[4] = 6'd0;
        drv(3'b111, {5'd4, 5'd5, 5'd4}, {6'd12, 6'd11, 6'd10},
            {6'd3, 6'd2, 6'd1}, 3'b000, 3'b000, '0);
        sb.push_back(ex(3'b111, {5'd4, 5'd5, 5'd4}, {6'd12, 6'd11, 6'd10},
                        3'b111, {6'd3, 6'd2, 6'd1}, 0, 0, 0, 2'd3, 0));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL same_ar got=%h exp=%h", g, e);
        else passed++;
        for (int i = 0; i < 3; i++)
            if (g.we[i]) amt[g.ar[i*5 +: 5]] = g.t[i*6 +: 6];
        total++;
        if (amt[4] !== 6'd12)
            $display("FAIL same_ar_amt4 got=%0d exp=12", amt[4]);
        else passed++;
        drv(3'b101, {5'd6, 5'd0, 5'd4}, {6'd14, 6'd0, 6'd13},
            {6'd6, 6'd0, 6'd12}, 3'b000, 3'b000, '0);
        sb.push_back(ex(3'b001, {5'd0, 5'd0, 5'd4}, {6'd0, 6'd0, 6'd13},
                        3'b001, {6'd0, 6'd0, 6'd12}, 0, 0, 0, 2'd1, 1));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL gap got=%h exp=%h", g, e);
        else passed++;
    endtask

    task automatic test_pse_halt();
        do_reset();
        drv(3'b111, {5'd3, 5'd2, 5'd1}, {6'd3, 6'd2, 6'd9},
            {6'd3, 6'd2, 6'd8}, 3'b001, 3'b001, {32'h0, 32'h0, 32'h2000});
        sb.push_back(ex(3'b001, {5'd0, 5'd0, 5'd1}, {6'd0, 6'd0, 6'd9},
                        3'b001, {6'd0, 6'd0, 6'd8}, 0, 0, 1, 2'd1, 0));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL pse_halt got=%h exp=%h", g, e);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [14:0] ar;
        logic [17:0] t, told;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                ar[i*5 +: 5]   = 5'(8 + 3*k + i);
                t[i*6 +: 6]    = 6'(16 + 3*k + i);
                told[i*6 +: 6] = 6'(32 + 3*k + i);
            end
            drv(3'b111, ar, t, told, 3'b000, 3'b000, '0);
            sb.push_back(ex(3'b111, ar, t, 3'b111, told, 0, 0, 0, 2'd3, 0));
            tick();
            g = sample(); e = sb.pop_front(); total++;
            if (g !== e) $display("FAIL b2b%0d got=%h exp=%h", k, g, e);
            else passed++;
        end
        idle();
        sb.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        g = sample(); e = sb.pop_front(); total++;
        if (g !== e) $display("FAIL b2b_idle got=%h exp=%h", g, e);
        else passed++;
    endtask

`ifdef RETIRE_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drv(3'b111, {5'd3, 5'd2, 5'd1}, {6'd3, 6'd2, 6'd1},
                {6'd6, 6'd5, 6'd4}, 3'b000, (k == 9) ? 3'b100 : 3'b000,
                {32'h4000, 64'h0});
            tick();
        end
        idle();
        repeat (4) tick();
        total++;
        if (stat_retired !== 32'd30 || stat_squashes !== 32'd1)
            $display("FAIL stats got=%0d/%0d exp=30/1",
                     stat_retired, stat_squashes);
        else passed++;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle();
        test_reset();
        test_basic();
        test_ar_zero();
        test_squash();
        test_halt();
        test_same_ar();
        test_pse_halt();
        test_back_to_back();
`ifdef RETIRE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
